// File: rtl/divider.sv
// divider: restoring radix-2 unsigned divider, 2*WIDTH-bit dividend by WIDTH-bit divisor, valid/ready handshake.
// Define DIVIDER_DIVZERO_FAST_EN to finish divide-by-zero the cycle after accept instead of running the datapath.
module divider #(
  parameter int WIDTH = 40
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [2*WIDTH-1:0]   dividend_in,
  input  logic [WIDTH-1:0]     divisor_in,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [2*WIDTH-1:0]   quotient_out,
  output logic [WIDTH-1:0]     remainder_out,
  output logic                 err_out
);
  localparam int CW = $clog2(2*WIDTH+1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [2*WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               accept, div_zero, fast_zero, ge;
  logic [WIDTH:0]     shifted, diff;
  assign accept   = valid_in && (state_q == IDLE);
  assign div_zero = (divisor_in == '0);
`ifdef DIVIDER_DIVZERO_FAST_EN
  assign fast_zero = div_zero;
`else
  assign fast_zero = 1'b0;
`endif
  // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom
  assign shifted = (rem_q << 1) | {{WIDTH{1'b0}}, dq_q[2*WIDTH-1]};
  assign diff    = shifted - {1'b0, div_q};
  assign ge      = shifted >= {1'b0, div_q};
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = valid_in ? (fast_zero ? DONE : BUSY) : IDLE;
      BUSY:    state_d = (cnt_q == CW'(1)) ? DONE : BUSY;
      DONE:    state_d = ready_in ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ready_out = (state_q == IDLE);
    valid_out = (state_q == DONE);
  end
  always_comb begin
    dq_d  = dq_q;
    rem_d = rem_q;
    div_d = div_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (accept) begin
      dq_d  = fast_zero ? '1 : dividend_in;
      rem_d = fast_zero ? {1'b0, dividend_in[WIDTH-1:0]} : '0;
      div_d = divisor_in;
      cnt_d = fast_zero ? '0 : CW'(2*WIDTH);
      err_d = div_zero;
    end else if (state_q == BUSY) begin
      dq_d  = {dq_q[2*WIDTH-2:0], ge};
      rem_d = ge ? diff : shifted;
      cnt_d = cnt_q - CW'(1);
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dq_q  <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      dq_q  <= dq_d;
      rem_q <= rem_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign quotient_out  = dq_q;
  assign remainder_out = rem_q[WIDTH-1:0];
  assign err_out       = err_q;
endmodule
